// File: rtl/div_sched.sv
// rtl/div_sched.sv - two-port round-robin scheduler/sequencer for the shared shift-subtract divider
//
// Purpose: arbitrates two requesters round-robin, latches the winner's operands,
// sequences the divider datapath (load, WIDTH steps, final fix-up) and returns a
// tagged response with a divide-by-zero flag.
//
// Optional feature macro: DIV_DBZ_FAST_EN
//   defined   - a zero divisor skips the datapath and responds one cycle after acceptance
//   undefined - a zero divisor runs the full LOAD/ITER/FIX sequence
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid[1:0]           per-requester request valid
//   req_ready[1:0]           per-requester accept (combinational, one-hot or zero)
//   a0, b0 / a1, b1          requester 0 / 1 dividend and divisor
//   dp_dividend, dp_divisor  registered operands to the datapath
//   dp_load, dp_step, dp_final  datapath strobes (mutually exclusive)
//   rsp_valid, rsp_id, rsp_dbz  response handshake, owner and zero-divisor flag
//   rsp_ready                consumer accepts the response
//   busy                     high whenever the scheduler is not idle

module div_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] dp_dividend,
    output logic [WIDTH-1:0] dp_divisor,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_final,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_dbz,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_zero;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_rsp_id;

    logic               w_grant;
    logic               w_accept;
    logic [WIDTH-1:0]   w_win_a;
    logic [WIDTH-1:0]   w_win_b;
    logic               w_win_zero;
    logic               w_last_step;

    // Round-robin: with both valid, the requester not granted last time wins.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    assign w_accept    = (r_state == S_IDLE) && (|req_valid);
    assign w_win_a     = w_grant ? a1 : a0;
    assign w_win_b     = w_grant ? b1 : b0;
    assign w_win_zero  = (w_win_b == '0);
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand/tag capture and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_zero       <= 1'b0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dividend   <= w_win_a;
                r_divisor    <= w_win_b;
                r_rsp_id     <= w_grant;
                r_last_grant <= w_grant;
                r_zero       <= w_win_zero;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == S_ITER && !w_last_step) begin
                // Holding at WIDTH-1 on exit keeps the counter from ever wrapping.
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_DBZ_FAST_EN
                    w_next = w_win_zero ? S_RESP : S_LOAD;
`else
                    w_next = S_LOAD;
`endif
                end
            end
            S_LOAD:  w_next = S_ITER;
            S_ITER:  w_next = w_last_step ? S_FIX : S_ITER;
            S_FIX:   w_next = S_RESP;
            S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
        dp_load   = (r_state == S_LOAD);
        dp_step   = (r_state == S_ITER);
        dp_final  = (r_state == S_FIX);
        rsp_valid = (r_state == S_RESP);
        rsp_dbz   = (r_state == S_RESP) && r_zero;
        busy      = (r_state != S_IDLE);
    end

    assign dp_dividend = r_dividend;
    assign dp_divisor  = r_divisor;
    assign rsp_id      = r_rsp_id;

endmodule

// File: doc/div_sched.md
# div_sched

Two-port scheduler and sequencer for the shared unsigned shift-subtract divider. It arbitrates between two requesters round-robin, latches the winning operands, drives the divider datapath's load, step and final-fix strobes, and returns a tagged response with a divide-by-zero flag. It sits between the CPU-side request ports and the divider register/ALU datapath, and replaces free-running control of that datapath.

## Interface
- WIDTH, 32, operand width; also the number of step iterations
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; combinational; at most one bit high
- a0, b0  in  WIDTH each  requester 0 dividend and divisor
- a1, b1  in  WIDTH each  requester 1 dividend and divisor
- dp_dividend, dp_divisor  out  WIDTH each  registered operands to the datapath
- dp_load  out  1  datapath loads its operand registers
- dp_step  out  1  datapath performs one shift-left/subtract iteration
- dp_final  out  1  datapath shifts the remainder half right (fix-up)
- rsp_valid  out  1  result available in the datapath
- rsp_id  out  1  requester that owns the result
- rsp_dbz  out  1  divisor was zero
- rsp_ready  in  1  consumer takes the response
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, ITER, FIX, RESP.
- IDLE: grant is computed combinationally. With one valid bit, that requester wins. With both valid, the requester that is not last_grant wins. req_ready[grant] = 1 while in IDLE. On the accepting edge:
  - operands of the winner go to dp_dividend/dp_divisor
  - rsp_id <= grant, last_grant <= grant
  - zero flag <= (divisor == 0)
  - next state is LOAD
- LOAD: dp_load = 1 for 1 cycle; counter cleared; go to ITER.
- ITER: dp_step = 1 every cycle and the counter increments. After exactly WIDTH step cycles (counter == WIDTH-1), go to FIX.
- FIX: dp_final = 1 for 1 cycle; go to RESP.
- RESP: rsp_valid = 1 and rsp_dbz = zero flag. Hold until rsp_valid && rsp_ready, then go to IDLE.
- dp_load, dp_step, dp_final are mutually exclusive and decoded from the state.
- req_ready is 0 outside IDLE. A valid dropped before acceptance is ignored.
- dp_dividend, dp_divisor and rsp_id stay stable from acceptance until the next acceptance.

## Timing
- Reset values:
  - state IDLE, counter 0, last_grant 1 (so requester 0 has first priority), zero flag 0
  - dp_dividend 0, dp_divisor 0, rsp_id 0
  - all strobes 0, rsp_valid 0, busy 0
- Latency, acceptance edge to first rsp_valid cycle: WIDTH+3 cycles (35 for WIDTH=32). This is 1 LOAD + WIDTH ITER + 1 FIX + 1.
- Throughput: the RESP handshake edge returns to IDLE. The next acceptance is possible in the following cycle, so there is at least one IDLE cycle between jobs.
- Backpressure: rsp_ready low holds RESP indefinitely. No new request is accepted in that time, and rsp_valid, rsp_id and rsp_dbz stay constant.
- Simultaneous requests: grants alternate 0,1,0,1 while both stay valid.
- Reset in any state, including mid-ITER: immediate return to reset values. The in-flight job is dropped and produces no response.
- Counter never wraps; it is only compared in ITER.

## Configuration
- DIV_DBZ_FAST_EN defined: when the latched divisor is zero, the edge after acceptance goes straight to RESP. No dp_load, dp_step or dp_final pulses occur. rsp_valid is high 1 cycle after acceptance, with rsp_dbz = 1.
- DIV_DBZ_FAST_EN undefined: a zero divisor runs the full LOAD/ITER/FIX sequence (WIDTH+3 latency) with rsp_dbz = 1 in RESP.
- Nonzero divisors behave identically in both builds.

## Test plan
- Requester 0 only, a0=100, b0=7, rsp_ready=1 -> req_ready=01 for 1 cycle; dp_dividend=100 and dp_divisor=7; 1 dp_load pulse, exactly 32 consecutive dp_step pulses, 1 dp_final pulse; rsp_valid 35 cycles after acceptance with rsp_id=0 and rsp_dbz=0.
- Both valid from reset (a0=10,b0=3; a1=20,b1=4), held -> requester 0 is served first and requester 1 second; rsp_id sequence 0,1; the next grant with both still valid is 0.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid is held; req_ready stays 00 although req_valid=11; on rsp_ready=1, IDLE follows one cycle later.
- b1=0 from requester 1 -> rsp_id=1 and rsp_dbz=1. With DIV_DBZ_FAST_EN: rsp_valid 1 cycle after acceptance and no datapath strobes. Without it: latency 35 and 32 dp_step pulses.
- rst pulsed at the 10th dp_step cycle -> all outputs go to reset values asynchronously; no rsp_valid follows. A new request afterwards completes normally with rsp_id taken from the new grant.
- req_valid[0] pulsed for 1 cycle while busy -> no acceptance and no response for requester 0.
